count_display_driver: RTL and testbench

COUNT_DISPLAY_DRIVER -- requirements
Module: count_display_driver

---
 rtl/count_display_pkg.sv | 45 ++++
 rtl/bin2bcd_seq.sv | 72 +++++++
 rtl/count_display_driver.sv | 77 +++++++
 tb/tb_count_display_driver.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_display_pkg.sv
// Shared constants, segment patterns and converter state for the count display.
package count_display_pkg;

    localparam int NUM_DIGITS = 3;
    localparam int BCD_W      = 12;
    localparam int BIN_W      = 10;
    localparam int MAX_COUNT  = 999;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } conv_state_e;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Free-running double-dabble converter: one sample every 12 cycles
// (IDLE, 10 x SHIFT, DONE); results only move to the outputs in DONE.
module bin2bcd_seq
    import count_display_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             ovf,
    output logic             done
);

    conv_state_e      state;
    logic [BIN_W-1:0] bin_sr;
    logic [BCD_W-1:0] bcd_sr;
    logic [3:0]       cnt;
    logic             ovf_q;
    logic [BCD_W-1:0] bcd_adj;

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_sr[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_sr[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            bin_sr <= '0;
            bcd_sr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            bcd    <= '0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bin > BIN_W'(MAX_COUNT)) begin
                        bin_sr <= BIN_W'(MAX_COUNT);
                        ovf_q  <= 1'b1;
                    end else begin
                        bin_sr <= bin;
                        ovf_q  <= 1'b0;
                    end
                    bcd_sr <= '0;
                    cnt    <= 4'd10;
                    state  <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd   <= bcd_sr;
                    ovf   <= ovf_q;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/count_display_driver.sv
// Converts a 0..999 count to BCD and multiplexes it onto a 3-digit display.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module count_display_driver
    import count_display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [BIN_W-1:0] i_count,
    output logic [BCD_W-1:0] o_bcd,
    output logic             o_valid,
    output logic             o_ovf,
    output logic [6:0]       o_seg,
    output logic [2:0]       o_an
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    logic          wrap;
    logic [3:0]    digit;
    logic          blank;

    bin2bcd_seq u_conv (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bin   (i_count),
        .bcd   (o_bcd),
        .ovf   (o_ovf),
        .done  (o_valid)
    );

    assign wrap    = (presc == PW'(SCAN_DIV - 1));
    assign idx_nxt = !wrap ? idx : (idx == 2'd2) ? 2'd0 : idx + 2'd1;

    always_comb begin
        digit = o_bcd[11:8];
        unique case (idx_nxt)
            2'd0:    digit = o_bcd[3:0];
            2'd1:    digit = o_bcd[7:4];
            default: digit = o_bcd[11:8];
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign blank = ((idx_nxt == 2'd2) && (o_bcd[11:8] == 4'd0)) ||
                   ((idx_nxt == 2'd1) && (o_bcd[11:4] == 8'd0));
`else
    assign blank = 1'b0;
`endif

    // Segments follow the index every cycle; anodes only move on a wrap.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            presc <= '0;
            idx   <= 2'd0;
            o_seg <= SEG_BLANK;
            o_an  <= 3'b111;
        end else begin
            presc <= wrap ? '0 : presc + 1'b1;
            idx   <= idx_nxt;
            if (!o_valid) begin
                o_seg <= SEG_BLANK;
                o_an  <= 3'b111;
            end else begin
                o_seg <= blank ? SEG_BLANK : seg_encode(digit);
                if (wrap) begin
                    o_an <= ~(3'b001 << idx_nxt);
                end
            end
        end
    end

endmodule

// File: tb/tb_count_display_driver.sv
// Randomized self-checking bench for count_display_driver against a
// cycle-level arithmetic model of sampling, conversion and scanning.
module tb_count_display_driver;

    localparam int DIV = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [9:0]  i_count = '0;
    logic [11:0] o_bcd;
    logic        o_valid;
    logic        o_ovf;
    logic [6:0]  o_seg;
    logic [2:0]  o_an;

    count_display_driver #(.SCAN_DIV(DIV)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_count (i_count),
        .o_bcd   (o_bcd),
        .o_valid (o_valid),
        .o_ovf   (o_ovf),
        .o_seg   (o_seg),
        .o_an    (o_an)
    );

    always #5 i_clk = ~i_clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        int s;
        s = (v > 999) ? 999 : v;
        return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (d > 9) ? 7'h7F : tbl[d];
    endfunction

    function automatic logic [6:0] exp_seg(input logic [11:0] b, input int pos);
        int h;
        int t;
        int o;
        h = int'(b[11:8]);
        t = int'(b[7:4]);
        o = int'(b[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
        if (pos == 2 && h == 0) return 7'h7F;
        if (pos == 1 && h == 0 && t == 0) return 7'h7F;
`endif
        return seg_of(pos == 0 ? o : pos == 1 ? t : h);
    endfunction

    function automatic int pos_of(input logic [2:0] an);
        return (an == 3'b110) ? 0 : (an == 3'b101) ? 1 : 2;
    endfunction

    // Reference model: phase within the 12-cycle conversion period, scan position.
    int          m_ph;
    int          m_pc;
    int          m_idx;
    int          m_samp;
    int          stab;
    logic        m_valid;
    logic        m_ovf;
    logic [11:0] m_bcd;
    logic [2:0]  m_an;
    logic        chk_en = 1'b0;
    logic [2:0]  prev_an = 3'b111;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_ph = 0; m_pc = 0; m_idx = 0; m_samp = 0; stab = 0;
            m_valid = 1'b0; m_ovf = 1'b0; m_bcd = '0; m_an = 3'b111;
        end else begin
            stab++;
            if (m_pc == DIV - 1) begin
                m_pc  = 0;
                m_idx = (m_idx + 1) % 3;
                m_an  = m_valid ? ~(3'b001 << m_idx) : 3'b111;
            end else begin
                m_pc++;
            end
            if (m_ph == 0) m_samp = int'(i_count);
            if (m_ph == 11) begin
                if (!m_valid || m_bcd != to_bcd(m_samp)) stab = 0;
                m_bcd   = to_bcd(m_samp);
                m_ovf   = (m_samp > 999);
                m_valid = 1'b1;
            end
            m_ph = (m_ph + 1) % 12;
        end
    end

    always @(negedge i_clk) begin
        if (chk_en) begin
            check("valid", o_valid, m_valid);
            check("bcd", o_bcd, m_bcd);
            check("ovf", o_ovf, m_ovf);
            check("an", o_an, m_an);
            if (!m_valid) begin
                check("seg_off", o_seg, 7'h7F);
            end else if (stab >= 2 && $countones(~o_an) == 1) begin
                check("seg", o_seg, exp_seg(m_bcd, pos_of(o_an)));
            end
            if ($countones(~prev_an) == 1 && o_an != prev_an && !i_rst) begin
                check("an_rot", o_an, {prev_an[1:0], prev_an[2]});
            end
            prev_an = o_an;
        end
    end

    task automatic wait_ph(input int p);
        int k;
        k = 0;
        @(negedge i_clk);
        while (m_ph != p && k < 13) begin
            @(negedge i_clk);
            k++;
        end
        if (m_ph != p) check("ph_timeout", m_ph, p);
    endtask

    initial begin
        logic [2:0] seen;
        int         k;

        repeat (2) @(negedge i_clk);
        chk_en = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (11) @(negedge i_clk);
        check("valid_at_11", o_valid, 1'b0);
        @(negedge i_clk);
        check("valid_at_12", o_valid, 1'b1);
        check("bcd_zero", o_bcd, 12'h000);
        check("ovf_zero", o_ovf, 1'b0);

        i_count = 10'd999;
        repeat (30) @(negedge i_clk);
        check("bcd_999", o_bcd, 12'h999);
        seen = 3'b000;
        for (int i = 0; i < 12; i++) begin
            @(negedge i_clk);
            if ($countones(~o_an) == 1) begin
                check("seg_999", o_seg, 7'h10);
                seen = seen | ~o_an;
            end
        end
        check("an_all", seen, 3'b111);

        i_count = 10'd1023;
        repeat (25) @(negedge i_clk);
        check("bcd_sat", o_bcd, 12'h999);
        check("ovf_sat", o_ovf, 1'b1);
        i_count = 10'd5;
        k = 0;
        while (!(o_bcd == 12'h005 && !o_ovf) && k < 24) begin
            @(negedge i_clk);
            k++;
        end
        check("recover_24", {o_ovf, o_bcd}, {1'b0, 12'h005});

        i_count = 10'd0;
        repeat (25) @(negedge i_clk);
        wait_ph(4);
        i_count = 10'd57;
        wait_ph(0);
        check("old_held", o_bcd, 12'h000);
        wait_ph(0);
        check("new_57", o_bcd, 12'h057);

        i_count = 10'd7;
        repeat (30) @(negedge i_clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge i_clk);
            if (o_an == 3'b110) check("ones_7", o_seg, 7'h78);
`ifdef LEADING_ZERO_BLANK_EN
            if (o_an == 3'b101) check("tens_blank", o_seg, 7'h7F);
            if (o_an == 3'b011) check("hund_blank", o_seg, 7'h7F);
`else
            if (o_an == 3'b101) check("tens_zero", o_seg, 7'h40);
            if (o_an == 3'b011) check("hund_zero", o_seg, 7'h40);
`endif
        end

        repeat (40) begin
            i_count = 10'($urandom_range(0, 1023));
            repeat ($urandom_range(1, 30)) @(negedge i_clk);
        end

        wait_ph(5);
        #2 i_rst = 1'b1;
        #1;
        check("rst_bcd", o_bcd, 12'h000);
        check("rst_valid", o_valid, 1'b0);
        check("rst_ovf", o_ovf, 1'b0);
        check("rst_seg", o_seg, 7'h7F);
        check("rst_an", o_an, 3'b111);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        i_count = 10'd321;
        repeat (11) @(negedge i_clk);
        check("rst_valid_11", o_valid, 1'b0);
        @(negedge i_clk);
        check("rst_valid_12", o_valid, 1'b1);
        check("rst_bcd_321", o_bcd, 12'h321);

        repeat (5) @(negedge i_clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
